// File: rtl/raster_tile_scheduler.sv
// Walks nanotile origins for each triangle job, handshakes the pixel shader and ping-pongs its two output buffers.
// Optional bounding-box culling of the walk is enabled by defining RASTER_SCHED_BBOX_CULL_EN.
module raster_tile_scheduler #(
  parameter int FRAME_W  = 640,
  parameter int FRAME_H  = 480,
  parameter int NANO_DIM = 8
) (
  input  logic        BOARD_CLK,
  input  logic        RESET_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [39:0] job_box,
  input  logic        frame_start,
  output logic        clearZ,
  output logic        startRasterizing,
  input  logic        doneRasterizing,
  output logic        rasterTileID,
  output logic [9:0]  tileOffsetX,
  output logic [9:0]  tileOffsetY,
  output logic [9:0]  start_x,
  output logic [9:0]  start_y,
  output logic [1:0]  wb_req,
  output logic [19:0] wb_origin0,
  output logic [19:0] wb_origin1,
  input  logic        wb_release,
  input  logic        wb_release_id,
  output logic        job_done
);

  localparam int SHIFT = $clog2(NANO_DIM);
  localparam logic [9:0] TILES_X = 10'(FRAME_W / NANO_DIM);
  localparam logic [9:0] TILES_Y = 10'(FRAME_H / NANO_DIM);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT_LO, WAIT_HI, HANDOFF} state_t;

  state_t      state_r, state_nxt_s;
  logic        clear_pend_r, clear_pend_nxt_s;
  logic        job_ready_r, clear_z_r, start_r, job_done_r, cur_r;
  logic [1:0]  wb_req_r, wb_req_nxt_s;
  logic [19:0] wb_origin0_r, wb_origin1_r;
  logic [9:0]  cx_r, cy_r, first_x_r, last_x_r, last_y_r;
  logic [9:0]  first_x_s, first_y_s, last_x_s, last_y_s;
  logic [9:0]  box_x0_s, box_y0_s, box_x1_s, box_y1_s;
  logic [9:0]  tile_x_s, tile_y_s;
  logic        empty_s, last_s, go_s, accept_s, handoff_s;

  assign box_x0_s = job_box[39:30];
  assign box_y0_s = job_box[29:20];
  assign box_x1_s = job_box[19:10];
  assign box_y1_s = job_box[9:0];

`ifdef RASTER_SCHED_BBOX_CULL_EN
  logic [9:0] last_x_raw_s, last_y_raw_s;
  assign first_x_s    = box_x0_s >> SHIFT;
  assign first_y_s    = box_y0_s >> SHIFT;
  assign last_x_raw_s = (box_x1_s - 10'd1) >> SHIFT;
  assign last_y_raw_s = (box_y1_s - 10'd1) >> SHIFT;
  assign last_x_s     = (last_x_raw_s > TILES_X - 10'd1) ? TILES_X - 10'd1 : last_x_raw_s;
  assign last_y_s     = (last_y_raw_s > TILES_Y - 10'd1) ? TILES_Y - 10'd1 : last_y_raw_s;
  // A box starting beyond the frame edge has no overlapping nanotile.
  assign empty_s = (box_x1_s <= box_x0_s) || (box_y1_s <= box_y0_s) ||
                   (first_x_s > TILES_X - 10'd1) || (first_y_s > TILES_Y - 10'd1);
`else
  assign first_x_s = 10'd0;
  assign first_y_s = 10'd0;
  assign last_x_s  = TILES_X - 10'd1;
  assign last_y_s  = TILES_Y - 10'd1;
  assign empty_s   = (box_x1_s <= box_x0_s) || (box_y1_s <= box_y0_s);
`endif

  assign tile_x_s  = cx_r << SHIFT;
  assign tile_y_s  = cy_r << SHIFT;
  assign last_s    = (cx_r == last_x_r) && (cy_r == last_y_r);
  assign handoff_s = (state_r == HANDOFF);

  assign clear_pend_nxt_s = frame_start || (clear_pend_r && (state_r != CLEAR));
  // A handoff set takes priority over a release of the same buffer.
  assign wb_req_nxt_s[0] = (handoff_s && !cur_r) ? 1'b1 :
                           (wb_release && !wb_release_id) ? 1'b0 : wb_req_r[0];
  assign wb_req_nxt_s[1] = (handoff_s && cur_r) ? 1'b1 :
                           (wb_release && wb_release_id) ? 1'b0 : wb_req_r[1];

  // Next-state decode for the job walk and shader handshake.
  always_comb begin
    state_nxt_s = state_r;
    go_s        = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (clear_pend_r) begin
          state_nxt_s = CLEAR;
        end else if (job_valid && job_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = empty_s ? IDLE : ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: state_nxt_s = IDLE;
      ISSUE: begin
        if (!wb_req_r[cur_r] && doneRasterizing) begin
          go_s        = 1'b1;
          state_nxt_s = WAIT_LO;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_LO: state_nxt_s = doneRasterizing ? WAIT_LO : WAIT_HI;
      WAIT_HI: state_nxt_s = doneRasterizing ? HANDOFF : WAIT_HI;
      HANDOFF: state_nxt_s = last_s ? IDLE : ISSUE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, walk counters, buffer flags and registered outputs.
  always_ff @(posedge BOARD_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r      <= IDLE;
      clear_pend_r <= 1'b0;
      job_ready_r  <= 1'b1;
      clear_z_r    <= 1'b0;
      start_r      <= 1'b0;
      job_done_r   <= 1'b0;
      cur_r        <= 1'b0;
      wb_req_r     <= 2'b00;
      wb_origin0_r <= 20'd0;
      wb_origin1_r <= 20'd0;
      cx_r         <= 10'd0;
      cy_r         <= 10'd0;
      first_x_r    <= 10'd0;
      last_x_r     <= 10'd0;
      last_y_r     <= 10'd0;
    end else begin
      state_r      <= state_nxt_s;
      clear_pend_r <= clear_pend_nxt_s;
      job_ready_r  <= (state_nxt_s == IDLE) && !clear_pend_nxt_s;
      clear_z_r    <= (state_nxt_s == CLEAR);
      start_r      <= go_s;
      job_done_r   <= (accept_s && empty_s) || (handoff_s && last_s);
      wb_req_r     <= wb_req_nxt_s;
      if (accept_s) begin
        cx_r      <= first_x_s;
        cy_r      <= first_y_s;
        first_x_r <= first_x_s;
        last_x_r  <= last_x_s;
        last_y_r  <= last_y_s;
      end else if (handoff_s && !last_s) begin
        if (cx_r == last_x_r) begin
          cx_r <= first_x_r;
          cy_r <= cy_r + 10'd1;
        end else begin
          cx_r <= cx_r + 10'd1;
        end
      end
      if (handoff_s) begin
        cur_r <= ~cur_r;
        if (cur_r) wb_origin1_r <= {tile_y_s, tile_x_s};
        else       wb_origin0_r <= {tile_y_s, tile_x_s};
      end
    end
  end

  assign job_ready        = job_ready_r;
  assign clearZ           = clear_z_r;
  assign startRasterizing = start_r;
  assign job_done         = job_done_r;
  assign rasterTileID     = cur_r;
  assign tileOffsetX      = tile_x_s;
  assign tileOffsetY      = tile_y_s;
  assign start_x          = 10'd0;
  assign start_y          = 10'd0;
  assign wb_req           = wb_req_r;
  assign wb_origin0       = wb_origin0_r;
  assign wb_origin1       = wb_origin1_r;

endmodule

// File: tb/tb_raster_tile_scheduler.sv
// Directed bench for raster_tile_scheduler; expected walk range follows RASTER_SCHED_BBOX_CULL_EN.
module tb_raster_tile_scheduler;

  logic        BOARD_CLK = 1'b0;
  logic        RESET_n;
  logic        job_valid, job_ready;
  logic [39:0] job_box;
  logic        frame_start, clearZ, startRasterizing, doneRasterizing, rasterTileID;
  logic [9:0]  tileOffsetX, tileOffsetY, start_x, start_y;
  logic [1:0]  wb_req;
  logic [19:0] wb_origin0, wb_origin1;
  logic        wb_release, wb_release_id, job_done;

`ifdef RASTER_SCHED_BBOX_CULL_EN
  localparam int MX0 = 1, MX1 = 2, MY0 = 1, MY1 = 1;
`else
  localparam int MX0 = 0, MX1 = 79, MY0 = 0, MY1 = 59;
`endif

  int checks = 0;
  int errors = 0;
  int idx    = 0;

  raster_tile_scheduler dut (
    .BOARD_CLK(BOARD_CLK), .RESET_n(RESET_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_box(job_box),
    .frame_start(frame_start), .clearZ(clearZ),
    .startRasterizing(startRasterizing), .doneRasterizing(doneRasterizing),
    .rasterTileID(rasterTileID), .tileOffsetX(tileOffsetX), .tileOffsetY(tileOffsetY),
    .start_x(start_x), .start_y(start_y), .wb_req(wb_req),
    .wb_origin0(wb_origin0), .wb_origin1(wb_origin1),
    .wb_release(wb_release), .wb_release_id(wb_release_id), .job_done(job_done)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge BOARD_CLK);
    #1;
  endtask

  task automatic wait_start(input int bound);
    int n = 0;
    while (startRasterizing !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk("start_seen", 32'(startRasterizing), 32'd1);
  endtask

  task automatic run_tile(input int ex, input int ey, input int b, input bit last, input bit rel);
    logic [19:0] org;
    org = {10'(ey * 8), 10'(ex * 8)};
    wait_start(8);
    chk("tile_x", 32'(tileOffsetX), 32'(ex * 8));
    chk("tile_y", 32'(tileOffsetY), 32'(ey * 8));
    chk("tile_id", 32'(rasterTileID), 32'(b));
    doneRasterizing = 1'b0;
    step();
    chk("start_width", 32'(startRasterizing), 32'd0);
    chk("tile_stable", 32'(tileOffsetX), 32'(ex * 8));
    doneRasterizing = 1'b1;
    step();
    step();
    chk("wb_req_set", 32'(wb_req[b]), 32'd1);
    chk("wb_origin", 32'((b == 1) ? wb_origin1 : wb_origin0), 32'(org));
    chk("job_done", 32'(job_done), 32'(last));
    if (rel) begin
      wb_release    = 1'b1;
      wb_release_id = b[0];
      step();
      wb_release = 1'b0;
      chk("wb_req_clr", 32'(wb_req[b]), 32'd0);
    end
  endtask

  initial begin
    RESET_n = 1'b0; job_valid = 1'b0; job_box = 40'd0; frame_start = 1'b0;
    doneRasterizing = 1'b1; wb_release = 1'b0; wb_release_id = 1'b0;
    step(); step();
    chk("rst_ready", 32'(job_ready), 32'd1);
    chk("rst_start", 32'(startRasterizing), 32'd0);
    chk("rst_clearz", 32'(clearZ), 32'd0);
    chk("rst_wbreq", 32'(wb_req), 32'd0);
    chk("rst_done", 32'(job_done), 32'd0);
    chk("rst_tx", 32'(tileOffsetX), 32'd0);
    chk("rst_ty", 32'(tileOffsetY), 32'd0);
    chk("rst_id", 32'(rasterTileID), 32'd0);
    chk("rst_org0", 32'(wb_origin0), 32'd0);
    RESET_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(job_ready), 32'd1);
    chk("start_x_zero", 32'(start_x), 32'd0);
    chk("start_y_zero", 32'(start_y), 32'd0);

    // Main job with a frame_start arriving mid-walk.
    job_box = {10'd10, 10'd10, 10'd20, 10'd12};
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    chk("busy_ready", 32'(job_ready), 32'd0);
    chk("start_lat1", 32'(startRasterizing), 32'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("start_lat2", 32'(startRasterizing), 32'd1);
    chk("no_clear_mid", 32'(clearZ), 32'd0);
    for (int cy = MY0; cy <= MY1; cy++) begin
      for (int cx = MX0; cx <= MX1; cx++) begin
        run_tile(cx, cy, idx % 2, (cx == MX1) && (cy == MY1), 1'b1);
        idx++;
      end
    end
    chk("clearz_pulse", 32'(clearZ), 32'd1);
    chk("ready_in_clear", 32'(job_ready), 32'd0);
    chk("start_in_clear", 32'(startRasterizing), 32'd0);
    step();
    chk("clearz_end", 32'(clearZ), 32'd0);
    chk("ready_after_clear", 32'(job_ready), 32'd1);

    // Empty box completes immediately.
    job_box = {10'd5, 10'd5, 10'd5, 10'd9};
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    chk("empty_done", 32'(job_done), 32'd1);
    chk("empty_ready", 32'(job_ready), 32'd1);
    chk("empty_nostart", 32'(startRasterizing), 32'd0);
    step();
    chk("empty_done_end", 32'(job_done), 32'd0);
    chk("empty_nostart2", 32'(startRasterizing), 32'd0);

    // Writeback stall, release latency, set-wins, reset mid-job.
    job_box = {10'd0, 10'd0, 10'd40, 10'd8};
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    run_tile(0, 0, 0, 1'b0, 1'b0);
    run_tile(1, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_start", 32'(startRasterizing), 32'd0);
    end
    chk("stall_wbreq", 32'(wb_req), 32'd3);
    chk("stall_id", 32'(rasterTileID), 32'd0);
    chk("stall_tx", 32'(tileOffsetX), 32'd16);
    wb_release = 1'b1; wb_release_id = 1'b0;
    step();
    wb_release = 1'b0;
    chk("rel_lat0", 32'(startRasterizing), 32'd0);
    chk("rel_wbreq", 32'(wb_req), 32'd2);
    step();
    chk("rel_lat1", 32'(startRasterizing), 32'd1);
    chk("rel_id", 32'(rasterTileID), 32'd0);
    chk("rel_tx", 32'(tileOffsetX), 32'd16);
    doneRasterizing = 1'b0; wb_release = 1'b1; wb_release_id = 1'b1;
    step();
    wb_release = 1'b0;
    chk("rel1_wbreq", 32'(wb_req), 32'd0);
    doneRasterizing = 1'b1;
    step(); step();
    chk("t2_wbreq", 32'(wb_req), 32'd1);
    chk("t2_notdone", 32'(job_done), 32'd0);
    step();
    chk("t3_start", 32'(startRasterizing), 32'd1);
    chk("t3_tx", 32'(tileOffsetX), 32'd24);
    chk("t3_id", 32'(rasterTileID), 32'd1);
    doneRasterizing = 1'b0;
    step();
    doneRasterizing = 1'b1;
    step();
    wb_release = 1'b1; wb_release_id = 1'b1;
    step();
    wb_release = 1'b0;
    chk("set_wins", 32'(wb_req), 32'd3);
    wb_release = 1'b1; wb_release_id = 1'b0;
    step();
    wb_release = 1'b0;
    step();
    chk("t4_start", 32'(startRasterizing), 32'd1);
    chk("t4_tx", 32'(tileOffsetX), 32'd32);
    chk("t4_id", 32'(rasterTileID), 32'd0);
    doneRasterizing = 1'b0;
    step();
    chk("t4_start_end", 32'(startRasterizing), 32'd0);
    #2;
    RESET_n = 1'b0;
    #1;
    chk("arst_ready", 32'(job_ready), 32'd1);
    chk("arst_wbreq", 32'(wb_req), 32'd0);
    chk("arst_start", 32'(startRasterizing), 32'd0);
    chk("arst_tx", 32'(tileOffsetX), 32'd0);
    chk("arst_done", 32'(job_done), 32'd0);
    RESET_n = 1'b1;
    doneRasterizing = 1'b1;
    step();
    chk("idle_ready", 32'(job_ready), 32'd1);
    chk("idle_wbreq", 32'(wb_req), 32'd0);
    chk("idle_start", 32'(startRasterizing), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
